program_dispatcher: RTL and testbench
=====================================

# program_dispatcher

Downstream stage of the input manager: captures each one-cycle `program_out` strobe with its `x_out`/`y_out`/`data_out` payload into a small FIFO. It replays the entries to the render-grid write port over a valid/ready handshake. After every `BATCH_LEN` completed grid writes it pulses `resume` back to the input manager, which releases the next batch.

## Interface
- `FIFO_DEPTH`, 8: entries buffered; power of two, ≥2.
- `BATCH_LEN`, 35: grid writes per batch before `resume` pulses; 1..65535.
- `GRID_W`, 1920: valid x range 0..GRID_W-1 (used only with the bounds-check feature).
- `GRID_H`, 1080: valid y range 0..GRID_H-1 (used only with the bounds-check feature).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `program_in` in 1: push strobe; one entry per high cycle.
- `x_in` in 11: x coordinate, sampled with `program_in`.
- `y_in` in 12: y coordinate, sampled with `program_in`.
- `data_in` in 32: payload, sampled with `program_in`.
- `resume` out 1: one-cycle pulse to the input manager at the end of each batch.
- `wr_valid` out 1: a grid write is offered.
- `wr_ready` in 1: grid accepts the write.
- `wr_x` out 11, `wr_y` out 12, `wr_data` out 32: write payload; stable while `wr_valid` is high and `wr_ready` is low.
- `busy` out 1: FIFO is non-empty or the FSM is not IDLE.
- `overflow` out 1: sticky; a push was dropped.
- `oob` out 1: sticky; an out-of-range entry was dropped. Tied to 0 when the bounds-check feature is compiled out.

## Operation
- FIFO: circular buffer with log2(FIFO_DEPTH)+1-bit read and write pointers. Full means the MSBs differ and the low bits are equal; empty means the pointers are equal.
- Push: accepted when `program_in` is high and (not full, or a pop happens in the same cycle). A push when full with no same-cycle pop is dropped and sets `overflow`.
- Pop: occurs when `wr_valid & wr_ready`. `wr_valid` = FIFO non-empty, except in RESUME.
- Output is show-ahead: `wr_x`/`wr_y`/`wr_data` present the head entry combinationally from storage.
- Batch counter: 16 bits, increments on each pop.
- FSM:
  - IDLE: no traffic yet. The first accepted push moves to STREAM.
  - STREAM: normal flow. When the counter reaches BATCH_LEN-1 and a pop occurs, clear the counter and go to RESUME.
  - RESUME: one cycle. `resume`=1 and `wr_valid` forced to 0; pushes are still accepted. Next state is STREAM if the FIFO is non-empty, else IDLE.
- Simultaneous push and pop on an empty FIFO is impossible, because `wr_valid` is low when empty. The push lands and is offered the next cycle.
- Reset, including mid-transfer: pointers, counter, and flags are cleared; the FSM goes to IDLE; all FIFO contents are discarded.

## Timing
- Reset values: `resume`=0, `wr_valid`=0, `busy`=0, `overflow`=0, `oob`=0. `wr_x`/`wr_y`/`wr_data` are don't-care while `wr_valid`=0.
- Latency: a push in cycle N gives `wr_valid`=1 in cycle N+1 when the FIFO was empty. Occupancy after a push into an empty FIFO is 1 in cycle N+1.
- Throughput: one write per cycle while `wr_ready`=1 and the FIFO is non-empty, except one bubble per batch for the RESUME cycle.
- `resume` rises in the cycle after the BATCH_LEN-th handshake and is high for exactly one cycle.
- `overflow` and `oob` set in the cycle after the offending push and hold until `rst`.

## Configuration
- `PROGRAM_DISPATCHER_BOUNDS_CHECK_EN` defined:
  - A push with `x_in`≥GRID_W or `y_in`≥GRID_H is not written into the FIFO.
  - The dropped entry sets `oob` and does not count toward the batch.
  - A push that is both full-dropped and out of range sets only `oob`.
- Not defined: all pushes are stored regardless of coordinates; `oob` is tied to 0.

## Test plan
- Reset, then push 35 entries with x=i, y=2i, data=0xA000_0000+i and `wr_ready`=1 → 35 in-order writes with matching payloads. `resume` pulses once, in the cycle after write 35; FSM returns to IDLE; `busy`=0.
- With `wr_ready`=0, push 9 entries (FIFO_DEPTH=8) → `overflow`=1 from the cycle after push 9. Raise `wr_ready` → exactly the first 8 entries come out.
- FIFO full, and `program_in` and `wr_ready` both high in the same cycle → push accepted, no `overflow`, occupancy stays 8.
- Push 40 entries back-to-back, `wr_ready`=1 → `resume` after write 35, a one-cycle `wr_valid` gap, then writes 36-40. The counter reads 5 at the end.
- Assert `rst` while 4 entries are queued and `wr_valid`=1 → all outputs go to reset values immediately. A later single push appears as the only write.
- With `PROGRAM_DISPATCHER_BOUNDS_CHECK_EN`, push x=1920, y=0 and then x=5, y=5 → only (5,5) is written; `oob`=1; the batch counter equals 1.

Source files
------------

// File: rtl/program_dispatcher.sv
// program_dispatcher: FIFO-buffered replay of input-manager strobes to the grid write port with per-batch resume; optional bounds check via PROGRAM_DISPATCHER_BOUNDS_CHECK_EN
module program_dispatcher #(
    parameter int FIFO_DEPTH = 8,
    parameter int BATCH_LEN  = 35,
    parameter int GRID_W     = 1920,
    parameter int GRID_H     = 1080
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        program_in,
    input  logic [10:0] x_in,
    input  logic [11:0] y_in,
    input  logic [31:0] data_in,
    output logic        resume,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [10:0] wr_x,
    output logic [11:0] wr_y,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        overflow,
    output logic        oob
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, STREAM, RESUME} state_t;
    state_t state, state_nxt;
    logic [AW:0] wptr, rptr;
    logic [10:0] mem_x [FIFO_DEPTH];
    logic [11:0] mem_y [FIFO_DEPTH];
    logic [31:0] mem_d [FIFO_DEPTH];
    logic [15:0] batch_cnt;
    logic empty, full, in_range, push, pop, batch_end;
    assign empty     = wptr == rptr;
    assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign wr_valid  = !empty && state != RESUME;
    assign pop       = wr_valid && wr_ready;
    assign push      = program_in && in_range && (!full || pop);
    assign batch_end = batch_cnt == 16'(BATCH_LEN - 1);
    assign resume    = state == RESUME;
    assign busy      = !empty || state != IDLE;
    assign wr_x      = mem_x[rptr[AW-1:0]];
    assign wr_y      = mem_y[rptr[AW-1:0]];
    assign wr_data   = mem_d[rptr[AW-1:0]];
`ifdef PROGRAM_DISPATCHER_BOUNDS_CHECK_EN
    assign in_range = (32'(x_in) < 32'(GRID_W)) && (32'(y_in) < 32'(GRID_H));
    // out-of-range pushes are discarded and latched; they take precedence over overflow
    always_ff @(posedge clk or posedge rst)
        if (rst) oob <= 1'b0;
        else if (program_in && !in_range) oob <= 1'b1;
`else
    assign in_range = 1'b1;
    assign oob      = 1'b0;
`endif
    // storage is not reset: pointers alone define the valid contents
    always_ff @(posedge clk)
        if (push) begin
            mem_x[wptr[AW-1:0]] <= x_in;
            mem_y[wptr[AW-1:0]] <= y_in;
            mem_d[wptr[AW-1:0]] <= data_in;
        end
    // pointers, batch counter, sticky overflow and FSM state
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            batch_cnt <= '0;
            overflow  <= 1'b0;
            state     <= IDLE;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop) rptr <= rptr + (AW+1)'(1);
            if (pop) batch_cnt <= batch_end ? 16'd0 : batch_cnt + 16'd1;
            if (program_in && in_range && full && !pop) overflow <= 1'b1;
            state <= state_nxt;
        end
    // next state: a push that lands during RESUME keeps the stream alive
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = push ? STREAM : IDLE;
            STREAM:  state_nxt = (pop && batch_end) ? RESUME : STREAM;
            RESUME:  state_nxt = (!empty || push) ? STREAM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_program_dispatcher.sv
// tb_program_dispatcher: directed and random stimulus checked against a queue-based model; honours PROGRAM_DISPATCHER_BOUNDS_CHECK_EN
module tb_program_dispatcher;
    logic        clk, rst, program_in, wr_ready;
    logic [10:0] x_in, wr_x;
    logic [11:0] y_in, wr_y;
    logic [31:0] data_in, wr_data;
    logic        resume, wr_valid, busy, overflow, oob;

    typedef struct packed {logic [10:0] x; logic [11:0] y; logic [31:0] d;} ent_t;
    ent_t q[$];
    int mode;       // 0 idle, 1 streaming, 2 resume cycle
    int n_wr, n_res;
    bit ovf_m, oob_m;
    int total = 0, fails = 0;

    program_dispatcher dut (
        .clk(clk), .rst(rst), .program_in(program_in), .x_in(x_in), .y_in(y_in),
        .data_in(data_in), .resume(resume), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .busy(busy),
        .overflow(overflow), .oob(oob)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic model_clear();
        q.delete();
        mode = 0;
        n_wr = 0;
        ovf_m = 0;
        oob_m = 0;
    endtask

    // one clock: drive at negedge, compare outputs, advance the model across the posedge
    task automatic cyc(input logic p, input logic [10:0] x, input logic [11:0] y,
                       input logic [31:0] d, input logic r);
        logic ev, pp, ps, inr, hit;
        @(negedge clk);
        program_in = p; x_in = x; y_in = y; data_in = d; wr_ready = r;
        #1;
        ev = q.size() > 0 && mode != 2;
        chk("wr_valid", wr_valid, ev);
        chk("resume", resume, mode == 2);
        chk("busy", busy, q.size() > 0 || mode != 0);
        chk("overflow", overflow, ovf_m);
        chk("oob", oob, oob_m);
        if (ev) begin
            chk("wr_x", wr_x, q[0].x);
            chk("wr_y", wr_y, q[0].y);
            chk("wr_data", wr_data, q[0].d);
        end
        if (resume) n_res++;
        pp = ev && r;
        inr = 1;
`ifdef PROGRAM_DISPATCHER_BOUNDS_CHECK_EN
        inr = (x < 1920) && (y < 1080);
`endif
        ps = p && inr && (q.size() < 8 || pp);
        if (p && !inr) oob_m = 1;
        else if (p && q.size() == 8 && !pp) ovf_m = 1;
        hit = 0;
        if (pp) begin
            void'(q.pop_front());
            n_wr++;
            hit = (n_wr % 35) == 0;
        end
        if (ps) q.push_back('{x, y, d});
        case (mode)
            0: if (ps) mode = 1;
            1: if (hit) mode = 2;
            default: mode = q.size() > 0 ? 1 : 0;
        endcase
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, r);
    endtask

    // asynchronous reset asserted mid-cycle; outputs must clear without a clock edge
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1;
        program_in = 0;
        wr_ready = 0;
        #1;
        chk("rst_resume", resume, 0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_oob", oob, 0);
        model_clear();
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        rst = 1; program_in = 0; x_in = 0; y_in = 0; data_in = 0; wr_ready = 0;
        model_clear();
        n_res = 0;
        #2;
        chk("init_resume", resume, 0);
        chk("init_wr_valid", wr_valid, 0);
        chk("init_busy", busy, 0);
        chk("init_overflow", overflow, 0);
        chk("init_oob", oob, 0);
        @(negedge clk);
        rst = 0;
        // one full batch, streamed straight through
        for (int i = 0; i < 35; i++) cyc(1, 11'(i), 12'(2 * i), 32'hA000_0000 + 32'(i), 1);
        idle(4, 1);
        chk("batch_resume_count", n_res, 1);
        chk("batch_idle_busy", busy, 0);
        // overflow on the ninth push while stalled, then drain
        do_reset();
        for (int i = 0; i < 9; i++) cyc(1, 11'(i + 100), 12'(i), 32'h0B00_0000 + 32'(i), 0);
        idle(12, 1);
        // full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1, 11'(i), 12'(i), 32'hC000_0000 + 32'(i), 0);
        cyc(1, 11'd50, 12'd50, 32'hC0DE_0008, 1);
        idle(12, 1);
        // 40 back-to-back, then 30 more to complete the second batch
        do_reset();
        n_res = 0;
        for (int i = 0; i < 40; i++) cyc(1, 11'(i), 12'(i + 1), 32'hD000_0000 + 32'(i), 1);
        idle(3, 1);
        chk("forty_resume_count", n_res, 1);
        for (int i = 0; i < 30; i++) cyc(1, 11'(i + 500), 12'(i), 32'hD100_0000 + 32'(i), 1);
        idle(3, 1);
        chk("seventy_resume_count", n_res, 2);
        // reset while four entries wait, then a single push
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 11'(i), 12'(i), 32'hE000_0000 + 32'(i), 0);
        do_reset();
        cyc(1, 11'd7, 12'd9, 32'h1234_5678, 1);
        idle(4, 1);
        // coordinate bounds: (1920,0) is out of range when the check is compiled in
        do_reset();
        cyc(1, 11'd1920, 12'd0, 32'hF000_0000, 1);
        cyc(1, 11'd5, 12'd5, 32'hF000_0005, 1);
        idle(3, 1);
        // random traffic with an occasional reset
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            cyc(1'($urandom_range(0, 1)), 11'($urandom), 12'($urandom_range(0, 1300)),
                $urandom, 1'($urandom_range(0, 3) != 0));
        end
        idle(20, 1);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
